mem_port_arbiter: RTL and testbench

Shares one single-port synchronous SRAM between the fetch stage's instruction requests and the memory stage's load/store requests, so instruction and data can live in one unified memory. It sits between `stage1_fetch`/`stage4_memory` and a single memory macro. It accepts at most one request per cycle and tracks in-flight reads through a latency-matched tag pipeline, routing each response back to its owner. Data requests have priority over fetch; an optional fairness counter bounds fetch starvation.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between fetch and data requests: data wins, a latency-matched tag
// pipeline routes reads back to their owner. Define MEM_PORT_ARBITER_FAIRNESS_EN to bound fetch starvation.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_STREAK   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [ADDR_WIDTH-1:0]   if_req_addr,
  input  logic                    if_flush,
  output logic                    if_rsp_valid,
  output logic [DATA_WIDTH-1:0]   if_rsp_data,
  input  logic                    dm_req_valid,
  output logic                    dm_req_ready,
  input  logic [ADDR_WIDTH-1:0]   dm_req_addr,
  input  logic                    dm_req_we,
  input  logic [DATA_WIDTH-1:0]   dm_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_req_be,
  output logic                    dm_rsp_valid,
  output logic [DATA_WIDTH-1:0]   dm_rsp_data,
  output logic                    sram_en,
  output logic                    sram_we,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  output logic [DATA_WIDTH/8-1:0] sram_be,
  input  logic [DATA_WIDTH-1:0]   sram_rdata
);

  localparam int LAST = READ_LATENCY - 1;

  logic force_if;
  logic dm_acc;
  logic if_acc;

  assign dm_req_ready = dm_req_valid && !force_if;
  assign if_req_ready = if_req_valid && !if_flush && (!dm_req_valid || force_if);
  assign dm_acc       = dm_req_valid && dm_req_ready;
  assign if_acc       = if_req_valid && if_req_ready;

`ifdef MEM_PORT_ARBITER_FAIRNESS_EN
  localparam int SW = $clog2(MAX_STREAK + 1);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;

  assign force_if = (streak_q == SW'(MAX_STREAK)) && if_req_valid && !if_flush;

  // Only contested data wins count; saturate so a flush-blocked force cannot overflow.
  always_comb begin
    streak_d = streak_q;
    if (if_acc) begin
      streak_d = '0;
    end else if (dm_acc && if_req_valid && (streak_q != SW'(MAX_STREAK))) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign force_if = 1'b0;

  if (MAX_STREAK < 1) begin : g_max_streak_unused
  end
`endif

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_be    = '0;
    if (dm_acc) begin
      sram_en    = 1'b1;
      sram_we    = dm_req_we;
      sram_addr  = dm_req_addr;
      sram_wdata = dm_req_wdata;
      sram_be    = dm_req_be;
    end else if (if_acc) begin
      sram_en    = 1'b1;
      sram_addr  = if_req_addr;
      sram_be    = '1;
    end
  end

  // Tag pipeline: one bit-vector per field, bit index = stage.
  logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [READ_LATENCY-1:0] tag_dm_q, tag_dm_d;
  logic [READ_LATENCY-1:0] tag_st_q, tag_st_d;
  logic [READ_LATENCY-1:0] tag_kill_q, tag_kill_d;

  assign tag_vld_d[0]  = dm_acc || if_acc;
  assign tag_dm_d[0]   = dm_acc;
  assign tag_st_d[0]   = dm_acc && dm_req_we;
  assign tag_kill_d[0] = 1'b0;

  for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
    assign tag_vld_d[gi]  = tag_vld_q[gi-1];
    assign tag_dm_d[gi]   = tag_dm_q[gi-1];
    assign tag_st_d[gi]   = tag_st_q[gi-1];
    assign tag_kill_d[gi] = tag_kill_q[gi-1] ||
                            (if_flush && tag_vld_q[gi-1] && !tag_dm_q[gi-1]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld_q  <= '0;
      tag_dm_q   <= '0;
      tag_st_q   <= '0;
      tag_kill_q <= '0;
    end else begin
      tag_vld_q  <= tag_vld_d;
      tag_dm_q   <= tag_dm_d;
      tag_st_q   <= tag_st_d;
      tag_kill_q <= tag_kill_d;
    end
  end

  // A flush in the same cycle also suppresses a fetch response that is leaving now.
  assign if_rsp_valid = tag_vld_q[LAST] && !tag_dm_q[LAST] && !tag_kill_q[LAST] && !if_flush;
  assign dm_rsp_valid = tag_vld_q[LAST] && tag_dm_q[LAST];
  assign if_rsp_data  = if_rsp_valid ? sram_rdata : '0;
  assign dm_rsp_data  = (dm_rsp_valid && !tag_st_q[LAST]) ? sram_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: SRAM model plus a queue-based reference of grants and responses.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int RL = 3;
  localparam int MS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req_valid = 1'b0, if_flush = 1'b0;
  logic [AW-1:0] if_req_addr = '0;
  logic          dm_req_valid = 1'b0, dm_req_we = 1'b0;
  logic [AW-1:0] dm_req_addr = '0;
  logic [DW-1:0] dm_req_wdata = '0;
  logic [BW-1:0] dm_req_be = '0;
  logic          if_req_ready, if_rsp_valid, dm_req_ready, dm_rsp_valid;
  logic [DW-1:0] if_rsp_data, dm_rsp_data;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic [BW-1:0] sram_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .MAX_STREAK(MS)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
    .dm_req_we(dm_req_we), .dm_req_wdata(dm_req_wdata), .dm_req_be(dm_req_be),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_be(sram_be), .sram_rdata(sram_rdata)
  );

  // SRAM: 256 words, read data appears RL cycles after the strobe, garbage otherwise.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_pipe [RL];
  assign sram_rdata = rd_pipe[RL-1];

  always @(posedge clk) begin
    for (int i = RL - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
    rd_pipe[0] = (sram_en && !sram_we) ? mem[sram_addr[9:2]] : 32'h0BAD0BAD;
    if (sram_en && sram_we)
      for (int b = 0; b < BW; b++)
        if (sram_be[b]) mem[sram_addr[9:2]][8*b +: 8] = sram_wdata[8*b +: 8];
  end

  // Reference model state
  typedef struct {
    int          due;
    bit          owner;
    bit          killed;
    logic [31:0] data;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] shadow [256];
  int          m_streak = 0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_cycle();
    bit          force_f, g_if, g_dm, ev_if, ev_dm;
    logic [31:0] ed_if, ed_dm, addr, data;
    rsp_t        e;
    int          idx;
    force_f = 1'b0;
`ifdef MEM_PORT_ARBITER_FAIRNESS_EN
    force_f = (m_streak >= MS) && if_req_valid && !if_flush;
`endif
    // Data always wins unless fetch has been starved long enough; fetch never wins during a flush.
    g_dm = dm_req_valid && !force_f;
    g_if = !g_dm && if_req_valid && !if_flush;

    if (if_flush)
      foreach (q[k]) if (!q[k].owner) q[k].killed = 1'b1;

    ev_if = 1'b0; ev_dm = 1'b0; ed_if = '0; ed_dm = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (e.owner) begin
        ev_dm = 1'b1; ed_dm = e.data;
      end else if (!e.killed) begin
        ev_if = 1'b1; ed_if = e.data;
      end
    end

    addr = g_dm ? dm_req_addr : (g_if ? if_req_addr : '0);
    chk("dm_req_ready", dm_req_ready, g_dm);
    chk("if_req_ready", if_req_ready, g_if);
    chk("sram_en", sram_en, g_dm | g_if);
    chk("sram_we", sram_we, g_dm && dm_req_we);
    chk("sram_addr", sram_addr, addr);
    chk("sram_wdata", sram_wdata, g_dm ? dm_req_wdata : '0);
    chk("sram_be", sram_be, g_dm ? dm_req_be : (g_if ? 4'hF : 4'h0));
    chk("if_rsp_valid", if_rsp_valid, ev_if);
    chk("if_rsp_data", if_rsp_data, ed_if);
    chk("dm_rsp_valid", dm_rsp_valid, ev_dm);
    chk("dm_rsp_data", dm_rsp_data, ed_dm);

    if (g_dm || g_if) begin
      idx = int'(addr[9:2]);
      if (g_dm && dm_req_we) begin
        for (int b = 0; b < BW; b++)
          if (dm_req_be[b]) shadow[idx][8*b +: 8] = dm_req_wdata[8*b +: 8];
        data = '0;
      end else begin
        data = shadow[idx];
      end
      e.due = cyc + RL; e.owner = g_dm; e.killed = 1'b0; e.data = data;
      q.push_back(e);
      $display("[TB] cyc %0d accept %s addr %h we %0d", cyc, g_dm ? "D" : "I", addr, g_dm && dm_req_we);
    end

    if (g_if) m_streak = 0;
    else if (g_dm && if_req_valid && m_streak < MS) m_streak++;
    cyc++;
  endtask

  task automatic step(input bit iv, input logic [31:0] ia, input bit fl, input bit dv,
                      input logic [31:0] da, input bit we, input logic [31:0] wd, input logic [3:0] be);
    @(posedge clk); #1;
    if_req_valid = iv; if_req_addr = ia; if_flush = fl;
    dm_req_valid = dv; dm_req_addr = da; dm_req_we = we; dm_req_wdata = wd; dm_req_be = be;
    @(negedge clk);
    model_cycle();
  endtask

  task automatic idle();
    step(0, '0, 0, 0, '0, 0, '0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outs"}, {if_req_ready, dm_req_ready, if_rsp_valid, dm_rsp_valid, sram_en, sram_we}, '0);
    chk({tag, "_if_data"}, if_rsp_data, '0);
    chk({tag, "_dm_data"}, dm_rsp_data, '0);
    chk({tag, "_sram_addr"}, sram_addr, '0);
  endtask

  typedef struct {
    bit iv, fl, dv;
    bit exp_ir, exp_dr;
  } vec_t;

  vec_t        tbl[8];
  logic [11:0] pattern, exp_pattern;
  bit          seen;

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 1};
    tbl[2] = '{1, 0, 0, 1, 0};
    tbl[3] = '{1, 0, 1, 0, 1};
    tbl[4] = '{1, 1, 0, 0, 0};
    tbl[5] = '{1, 1, 1, 0, 1};
    tbl[6] = '{0, 1, 1, 0, 1};
    tbl[7] = '{0, 1, 0, 0, 0};

    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h5A000000 | (i * 32'h00010101);
    end
    mem[32'h10 >> 2]  = 32'hDEADBEEF;
    mem[32'h20 >> 2]  = 32'h11110020;
    mem[32'h200 >> 2] = 32'hA5A50200;
    mem[32'h40 >> 2]  = 32'h0;
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    for (int i = 0; i < RL; i++) rd_pipe[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #2 check_all_zero("reset");
    @(negedge clk); rst = 1'b1;

    // Grant truth table
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].iv, 32'h100 + 4 * i, tbl[i].fl, tbl[i].dv, 32'h180 + 4 * i, 0, '0, 4'hF);
      chk("tbl_if_ready", if_req_ready, tbl[i].exp_ir);
      chk("tbl_dm_ready", dm_req_ready, tbl[i].exp_dr);
    end
    repeat (RL) idle();

    // Lone fetch
    step(1, 32'h10, 0, 0, '0, 0, '0, '0);
    chk("lone_if_ready", if_req_ready, 1);
    seen = 1'b0;
    for (int k = 1; k <= RL; k++) begin
      idle();
      seen |= dm_rsp_valid;
      if (k == RL) begin
        chk("lone_if_rsp_valid", if_rsp_valid, 1);
        chk("lone_if_rsp_data", if_rsp_data, 32'hDEADBEEF);
      end
    end
    chk("lone_no_dm_rsp", seen, 0);

    // Contention: load wins, fetch follows
    step(1, 32'h20, 0, 1, 32'h200, 0, '0, 4'hF);
    chk("cont_dm_first", {if_req_ready, dm_req_ready}, 2'b01);
    step(1, 32'h20, 0, 0, '0, 0, '0, '0);
    chk("cont_if_second", if_req_ready, 1);
    for (int k = 2; k <= RL + 1; k++) begin
      idle();
      if (k == RL) chk("cont_dm_rsp", {dm_rsp_valid, dm_rsp_data}, {1'b1, 32'hA5A50200});
      if (k == RL + 1) chk("cont_if_rsp", {if_rsp_valid, if_rsp_data}, {1'b1, 32'h11110020});
    end

    // Store ack then read-back
    step(0, '0, 0, 1, 32'h40, 1, 32'h12345678, 4'b0011);
    chk("st_sram_we_be", {sram_we, sram_be}, {1'b1, 4'b0011});
    for (int k = 1; k <= RL; k++) begin
      idle();
      if (k == RL) chk("st_ack", {dm_rsp_valid, dm_rsp_data}, {1'b1, 32'h0});
    end
    step(0, '0, 0, 1, 32'h40, 0, '0, 4'hF);
    for (int k = 1; k <= RL; k++) begin
      idle();
      if (k == RL) chk("st_readback", {dm_rsp_valid, dm_rsp_data}, {1'b1, 32'h00005678});
    end

    // Flush kills in-flight fetches
    step(1, 32'h10, 0, 0, '0, 0, '0, '0);
    step(1, 32'h14, 0, 0, '0, 0, '0, '0);
    step(1, 32'h18, 1, 0, '0, 0, '0, '0);
    chk("flush_if_ready", if_req_ready, 0);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle();
      seen |= if_rsp_valid;
    end
    chk("flush_no_if_rsp", seen, 0);

    // Fairness grant pattern
    for (int k = 0; k < 12; k++) begin
      step(1, 32'h30, 0, 1, 32'h34, 0, '0, 4'hF);
      pattern[11-k] = dm_req_ready;
    end
`ifdef MEM_PORT_ARBITER_FAIRNESS_EN
    exp_pattern = 12'b1111_0111_1011;
`else
    exp_pattern = 12'b1111_1111_1111;
`endif
    chk("fair_pattern", pattern, exp_pattern);
    repeat (RL + 1) idle();

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 99) < 60, {22'd0, 8'($urandom_range(0, 255)), 2'b00},
           $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 50, {22'd0, 8'($urandom_range(0, 255)), 2'b00},
           1'($urandom), $urandom, 4'($urandom));
    end
    repeat (RL) idle();
    chk("drain_empty", q.size(), 0);

    // Reset with two loads in flight
    step(0, '0, 0, 1, 32'h200, 0, '0, 4'hF);
    step(0, '0, 0, 1, 32'h20, 0, '0, 4'hF);
    @(posedge clk); #1;
    dm_req_valid = 1'b0; dm_req_addr = '0; dm_req_be = '0;
    #1 rst = 1'b0;
    #1 check_all_zero("midrst");
    q.delete();
    m_streak = 0;
    cyc++;
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < RL + 2; k++) begin
      idle();
      seen |= dm_rsp_valid;
    end
    chk("midrst_no_stale", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
